rv32i_lsu: RTL and testbench
============================

# rv32i_lsu

Parametrised load/store unit that sits between the RV32I core's execute stage and the data bus. It replaces the core's single-cycle, always-ready bus drive with a valid/ready request handshake, a wait-state-tolerant bus handshake and a bus timeout. It also performs byte-lane steering, byte-enable generation and load sign/zero extension. It supports 32- and 64-bit data paths; the core stalls while the unit is busy.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width; legal values 32 or 64; byte-enable width is DATA_W/8
- TIMEOUT, 255, maximum bus wait cycles before the access is aborted; legal range 1..65535
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents an access
- req_ready  out  1  unit accepts the access this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64)
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or timeout; valid with rsp_valid
- busReq  out  1  bus access active
- busReady  in  1  bus completes the access this cycle
- busWe  out  1  bus write
- busAddr  out  ADDR_W  access address, low log2(DATA_W/8) bits forced to 0
- busWData  out  DATA_W  lane-replicated store data
- Byte_Enable  out  DATA_W/8  active byte lanes
- busRData  in  DATA_W  read data, sampled when busReq && busReady

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request.
  - If size is illegal, or addr is not a multiple of 2^size: go to RESP with err=1; no bus access is made.
  - Otherwise go to BUS and clear the wait counter.
- BUS:
  - busReq=1; busWe, busAddr, busWData and Byte_Enable are held stable from registered values.
  - On busReady: for loads, capture the formatted busRData; go to RESP with err=0.
  - Else, when the counter reaches TIMEOUT: go to RESP with err=1 and drop busReq.
  - Else increment the counter.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in BUS and RESP.
- Byte_Enable: base mask (1, 3, F, FF for sizes 0..3) shifted left by the address lane offset.
- busWData: the low 2^size bytes of req_wdata replicated across all lanes.
- Loads: busRData is shifted right by offset*8, masked to the size, then sign-extended from the top bit of the accessed width, or zero-extended when req_unsigned. For dword, or word on DATA_W=32, no extension applies.
- Store with busReady: rsp_rdata=0.
- busReady outside BUS is ignored.

## Timing
- Reset (asynchronous, reset=0): state IDLE; all outputs 0, including busReq, rsp_valid, rsp_err, rsp_rdata, Byte_Enable, busAddr and busWData. req_ready is 0 while reset is low and 1 from the first cycle after release.
- Latency with a zero-wait bus (busReady already high in the first BUS cycle):
  - accept at edge 0;
  - busReq high in cycle 1;
  - rsp_valid in cycle 2.
- Each bus wait cycle adds 1 cycle of latency. Throughput is at most one access per 3 cycles.
- Error latency:
  - misaligned/illegal access: rsp_valid with err, 1 cycle after accept;
  - timeout: rsp_valid TIMEOUT+2 cycles after accept.
- busReady arriving in the same cycle the counter hits TIMEOUT: completion wins, err=0.
- Reset asserted mid-BUS: busReq drops asynchronously and no response is issued for that access.

## Structure
- Package lsu_pkg holds:
  - lsu_size_e (BYTE, HALF, WORD, DWORD);
  - lsu_state_e (IDLE, BUS, RESP);
  - a function mapping size to base byte-enable mask.
- Sub-module lsu_lane_align is purely combinational and contains the store replication, byte-enable shift, and load shift/extend. The FSM, counter and registers stay in rv32i_lsu.

## Test plan
- Word store, DATA_W=32, addr 0x1000_0004, wdata 0xDEAD_BEEF, busReady tied high -> busAddr 0x1000_0004, Byte_Enable 4'b1111, busWe=1, rsp_valid in cycle 2 with err=0.
- Signed byte load at 0x2000_0003, busRData 0x8000_0000 -> rsp_rdata 0xFFFF_FF80. Same access with req_unsigned -> 0x0000_0080. Byte_Enable 4'b1000.
- Half store at 0x3000_0002, wdata 0x0000_1234 -> busWData 0x1234_1234, Byte_Enable 4'b1100.
- Word load at 0x0000_0002 -> busReq never asserts; rsp_valid one cycle after accept with rsp_err=1.
- TIMEOUT=4, busReady held low -> busReq high for 5 cycles, then rsp_err=1. Repeat with busReady asserted in the 5th BUS cycle -> err=0.
- DATA_W=64, dword load at 0x8, busRData 0x0123_4567_89AB_CDEF -> Byte_Enable 8'hFF and rsp_rdata equal to busRData. Additionally, assert reset mid-BUS -> busReq=0 immediately, no rsp_valid, and req_ready=1 after release.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, DWORD = 2'd3} lsu_size_e;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} lsu_state_e;

  // Byte-enable pattern for an access at lane offset 0.
  function automatic logic [7:0] size_be_mask(lsu_size_e size);
    case (size)
      BYTE:    return 8'h01;
      HALF:    return 8'h03;
      WORD:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Core request/response and data-bus signals of the load/store unit.
interface rv32i_lsu_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  lsu_size_e             req_size;
  logic                  req_unsigned;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  busReq;
  logic                  busReady;
  logic                  busWe;
  logic [ADDR_W-1:0]     busAddr;
  logic [DATA_W-1:0]     busWData;
  logic [DATA_W/8-1:0]   Byte_Enable;
  logic [DATA_W-1:0]     busRData;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, busReady, busRData,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busReq, busWe, busAddr, busWData,
           Byte_Enable
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, busReady, busRData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busReq, busWe, busAddr, busWData,
           Byte_Enable
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store replication, byte enables, load shift/extend.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  off,
  input  lsu_size_e         size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sgn;

  always_comb begin
    be = NB'(size_be_mask(size)) << off;

    case (size)
      BYTE:    wdata_rep = {NB{wdata[7:0]}};
      HALF:    wdata_rep = {(NB/2){wdata[15:0]}};
      WORD:    wdata_rep = {(NB/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase

    shifted = rdata >> {off, 3'b000};
    // Full-width accesses keep every bit, so the fill value never reaches the result.
    case (size)
      BYTE: begin
        keep = DATA_W'(8'hFF);
        sgn  = shifted[7];
      end
      HALF: begin
        keep = DATA_W'(16'hFFFF);
        sgn  = shifted[15];
      end
      WORD: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sgn  = shifted[31];
      end
      default: begin
        keep = '1;
        sgn  = shifted[DATA_W-1];
      end
    endcase
    ld_data = (shifted & keep) | (~keep & {DATA_W{sgn & ~is_unsigned}});
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit: valid/ready core request, wait-state tolerant bus access with timeout.
module rv32i_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  rv32i_lsu_if.slave  port
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_e        state_q;
  logic [15:0]       cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_e         size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [2:0]        mis_mask;
  logic              bad_req;
  logic              in_bus;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_ld;

  always_comb begin
    case (port.req_size)
      BYTE:    mis_mask = 3'b000;
      HALF:    mis_mask = 3'b001;
      WORD:    mis_mask = 3'b011;
      default: mis_mask = 3'b111;
    endcase
    bad_req = ((port.req_size == DWORD) && (DATA_W == 32)) ||
              ((port.req_addr[2:0] & mis_mask) != 3'b000);
  end

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .off         (addr_q[OFF_W-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (port.busRData),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .ld_data     (al_ld)
  );

  // Bus outputs are decoded from registered state so reset clears them asynchronously.
  assign in_bus           = (state_q == BUS);
  assign port.busReq      = in_bus;
  assign port.busWe       = in_bus & we_q;
  assign port.busAddr     = in_bus ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign port.busWData    = in_bus ? al_wdata : '0;
  assign port.Byte_Enable = in_bus ? al_be : '0;
  assign port.req_ready   = req_ready_q;
  assign port.rsp_valid   = rsp_valid_q;
  assign port.rsp_err     = rsp_err_q;
  assign port.rsp_rdata   = rsp_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_ready_q && port.req_valid) begin
            we_q        <= port.req_we;
            addr_q      <= port.req_addr;
            size_q      <= port.req_size;
            uns_q       <= port.req_unsigned;
            wdata_q     <= port.req_wdata;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (bad_req) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= BUS;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        BUS: begin
          // Completion takes priority over a timeout in the same cycle.
          if (port.busReady) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : al_ld;
          end else if (cnt_q == 16'(TIMEOUT)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=6) instance against a model.
module tb_rv32i_lsu;
  import lsu_pkg::*;

  logic clk;
  logic reset;

  logic        sel;
  logic        valid;
  logic        we;
  logic        uns;
  logic        rdy;
  logic [1:0]  sz;
  logic [31:0] addr;
  logic [63:0] wd;
  logic [63:0] rd;

  int total = 0;
  int bad   = 0;

  rv32i_lsu_if #(.ADDR_W(32), .DATA_W(32)) i32 ();
  rv32i_lsu_if #(.ADDR_W(32), .DATA_W(64)) i64 ();

  rv32i_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk   (clk),
    .reset (reset),
    .port  (i32)
  );

  rv32i_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(6)) dut64 (
    .clk   (clk),
    .reset (reset),
    .port  (i64)
  );

  assign i32.req_valid    = valid & ~sel;
  assign i32.req_we       = we;
  assign i32.req_addr     = addr;
  assign i32.req_size     = lsu_size_e'(sz);
  assign i32.req_unsigned = uns;
  assign i32.req_wdata    = wd[31:0];
  assign i32.busReady     = rdy & ~sel;
  assign i32.busRData     = rd[31:0];

  assign i64.req_valid    = valid & sel;
  assign i64.req_we       = we;
  assign i64.req_addr     = addr;
  assign i64.req_size     = lsu_size_e'(sz);
  assign i64.req_unsigned = uns;
  assign i64.req_wdata    = wd;
  assign i64.busReady     = rdy & sel;
  assign i64.busRData     = rd;

  logic [63:0] m_ready, m_req, m_we, m_addr, m_be, m_wdata, m_rvalid, m_err, m_rdata;
  assign m_ready  = sel ? {63'b0, i64.req_ready} : {63'b0, i32.req_ready};
  assign m_req    = sel ? {63'b0, i64.busReq}    : {63'b0, i32.busReq};
  assign m_we     = sel ? {63'b0, i64.busWe}     : {63'b0, i32.busWe};
  assign m_addr   = sel ? {32'b0, i64.busAddr}   : {32'b0, i32.busAddr};
  assign m_be     = sel ? {56'b0, i64.Byte_Enable} : {60'b0, i32.Byte_Enable};
  assign m_wdata  = sel ? i64.busWData            : {32'b0, i32.busWData};
  assign m_rvalid = sel ? {63'b0, i64.rsp_valid} : {63'b0, i32.rsp_valid};
  assign m_err    = sel ? {63'b0, i64.rsp_err}   : {63'b0, i32.rsp_err};
  assign m_rdata  = sel ? i64.rsp_rdata           : {32'b0, i32.rsp_rdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h (dut%0d t=%0t)", tag, obs, exp, sel ? 64 : 32, $time);
    end
  endtask

  // One access; wait_n = wait cycles before busReady (beyond TIMEOUT means never).
  task automatic access(input bit s, input bit w, input logic [1:0] size, input logic [31:0] a,
                        input bit u, input logic [63:0] wdat, input logic [63:0] rdat,
                        input int wait_n);
    int          t, nb, nbytes, off, nbus;
    bit          err, to;
    logic [31:0] e_addr;
    logic [63:0] e_be, e_wd, e_ld, v, keep;
    t      = s ? 6 : 4;
    nb     = s ? 8 : 4;
    nbytes = 1 << size;
    err    = (nb == 4 && size == 2'd3) || (a % nbytes != 0);
    off    = a % nb;
    e_addr = a - off;
    e_be   = ((64'd1 << nbytes) - 64'd1) << off;
    e_wd   = '0;
    for (int i = 0; i < nb; i++) e_wd[8*i +: 8] = wdat[8*(i % nbytes) +: 8];
    v = rdat >> (8 * off);
    if (nbytes < nb) begin
      keep = (64'd1 << (8 * nbytes)) - 64'd1;
      v    = v & keep;
      if (!u && v[8*nbytes-1]) v = v | ~keep;
    end
    if (nb == 4) v = v & 64'hFFFF_FFFF;
    to   = wait_n > t;
    nbus = to ? t + 1 : wait_n + 1;
    e_ld = (w || to) ? 64'd0 : v;

    @(negedge clk);
    sel = s; valid = 1'b1; we = w; sz = size; addr = a; uns = u; wd = wdat; rd = rdat;
    rdy = (wait_n == 0);
    #1 chk("req_ready_idle", m_ready, 64'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    if (err) begin
      @(negedge clk);
      chk("err_no_busreq", m_req, 64'd0);
      chk("err_rsp_valid", m_rvalid, 64'd1);
      chk("err_rsp_err", m_err, 64'd1);
      chk("err_rsp_rdata", m_rdata, 64'd0);
    end else begin
      for (int k = 1; k <= nbus; k++) begin
        @(negedge clk);
        chk("busReq_bus", m_req, 64'd1);
        chk("no_rsp_in_bus", m_rvalid, 64'd0);
        if (k == 1 || k == nbus) begin
          chk("busAddr", m_addr, {32'b0, e_addr});
          chk("Byte_Enable", m_be, e_be);
          chk("busWe", m_we, {63'b0, w});
          if (w) chk("busWData", m_wdata, e_wd);
        end
        rdy = (k - 1 == wait_n);
      end
      @(negedge clk);
      rdy = 1'b0;
      chk("busReq_dropped", m_req, 64'd0);
      chk("rsp_valid", m_rvalid, 64'd1);
      chk("rsp_err", m_err, {63'b0, to});
      chk("rsp_rdata", m_rdata, e_ld);
    end
    @(negedge clk);
    chk("rsp_pulse_end", m_rvalid, 64'd0);
    chk("req_ready_back", m_ready, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; valid = 1'b0; we = 1'b0; uns = 1'b0; rdy = 1'b0;
    sz = 2'd0; addr = '0; wd = '0; rd = '0;
    reset = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      chk("rst_req_ready", m_ready, 64'd0);
      chk("rst_busReq", m_req, 64'd0);
      chk("rst_rsp_valid", m_rvalid, 64'd0);
      chk("rst_rsp_err", m_err, 64'd0);
      chk("rst_rsp_rdata", m_rdata, 64'd0);
      chk("rst_be", m_be, 64'd0);
      chk("rst_busAddr", m_addr, 64'd0);
      chk("rst_busWData", m_wdata, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    chk("ready_after_release", m_ready, 64'd1);

    // Directed steps.
    access(1'b0, 1'b1, 2'd2, 32'h1000_0004, 1'b0, 64'hDEAD_BEEF, 64'd0, 0);
    access(1'b0, 1'b0, 2'd0, 32'h2000_0003, 1'b0, 64'd0, 64'h8000_0000, 0);
    access(1'b0, 1'b0, 2'd0, 32'h2000_0003, 1'b1, 64'd0, 64'h8000_0000, 1);
    access(1'b0, 1'b1, 2'd1, 32'h3000_0002, 1'b0, 64'h0000_1234, 64'd0, 0);
    access(1'b0, 1'b0, 2'd2, 32'h0000_0002, 1'b0, 64'd0, 64'd0, 0);
    access(1'b0, 1'b0, 2'd2, 32'h0000_0040, 1'b0, 64'd0, 64'h1111_2222, 99);
    access(1'b0, 1'b0, 2'd2, 32'h0000_0040, 1'b0, 64'd0, 64'h1111_2222, 4);
    access(1'b0, 1'b0, 2'd3, 32'h0000_0008, 1'b0, 64'd0, 64'd0, 0);
    access(1'b0, 1'b0, 2'd1, 32'h0000_0006, 1'b0, 64'd0, 64'h9ABC_0000, 2);
    access(1'b1, 1'b0, 2'd3, 32'h0000_0008, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    access(1'b1, 1'b0, 2'd2, 32'h0000_000C, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 2);
    access(1'b1, 1'b0, 2'd2, 32'h0000_000C, 1'b1, 64'd0, 64'h8000_0000_0000_0000, 6);
    access(1'b1, 1'b1, 2'd0, 32'h0000_0105, 1'b0, 64'h0000_00A5, 64'd0, 99);
    access(1'b1, 1'b0, 2'd3, 32'h0000_0004, 1'b0, 64'd0, 64'd0, 0);

    // Reset while the 64-bit unit waits on the bus.
    @(negedge clk);
    sel = 1'b1; valid = 1'b1; we = 1'b0; sz = 2'd3; addr = 32'h10; rdy = 1'b0;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("midbus_busReq", m_req, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("midbus_rst_busReq", m_req, 64'd0);
    chk("midbus_rst_rsp", m_rvalid, 64'd0);
    chk("midbus_rst_ready", m_ready, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midbus_release_ready", m_ready, 64'd1);
    chk("midbus_release_rsp", m_rvalid, 64'd0);
    chk("midbus_release_busReq", m_req, 64'd0);
    @(negedge clk);
    chk("midbus_no_late_rsp", m_rvalid, 64'd0);

    // Randomized accesses on both widths.
    for (int n = 0; n < 60; n++) begin
      bit          s, w, u;
      logic [1:0]  size;
      logic [31:0] a;
      int          wt;
      s    = (n % 2) == 1;
      w    = $urandom_range(0, 1) == 1;
      u    = $urandom_range(0, 1) == 1;
      size = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 3) != 0) wt = $urandom_range(0, 2);
      else wt = $urandom_range(0, s ? 8 : 6);
      access(s, w, size, a, u, {$urandom, $urandom}, {$urandom, $urandom}, wt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
